pipe_hazard_ctrl: RTL and testbench

- Backward-direction control for the 5-stage pipeline. Consumes fields captured in the IF/ID, ID/EX, EX/MEM and MEM/WB registers and returns stall, bubble, flush and forwarding controls to those registers and to the PC.
- Small FSM handles multi-cycle data-memory waits with a timeout. Hazard controls are combinational from FSM state and inputs; FSM state is registered.

---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Backward hazard control for the 5-stage pipeline: stall/bubble/flush, operand forwarding,
// and a data-memory wait FSM with timeout. Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic [4:0]  idex_rs,
    input  logic [4:0]  idex_rt,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_wr,
    input  logic        exmem_RegWrite,
    input  logic [4:0]  exmem_wr,
    input  logic        exmem_mem_access,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  memwb_wr,
    input  logic        mem_ready,
    input  logic        ex_redirect,
    input  logic        id_jump,
    input  logic        perf_clr,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        bubble_idex,
    output logic        bubble_memwb,
    output logic        flush_ifid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err,
    output logic [1:0]  hz_state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10,
        ILLEGAL  = 2'b11
    } hzState_t;

    hzState_t          state;
    hzState_t          stateNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]  waitCntNext;

    logic stallPc, stallIfid, stallIdex, stallExmem;
    logic bubbleIdex, bubbleMemwb, flushIfid, memErr;
    logic [1:0] fwdA, fwdB;
    logic loadUse, memStall;

    assign memStall = exmem_mem_access && !mem_ready;
    assign loadUse  = idex_MemRead && (idex_wr != 5'd0) &&
                      ((idex_wr == ifid_rs) || (ifid_uses_rt && (idex_wr == ifid_rt)));

    // Forwarding: the younger MEM-stage writer wins over WB; r0 never forwards
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (exmem_RegWrite && (exmem_wr != 5'd0) && (exmem_wr == idex_rs))
            fwdA = 2'b10;
        else if (memwb_RegWrite && (memwb_wr != 5'd0) && (memwb_wr == idex_rs))
            fwdA = 2'b01;
        if (exmem_RegWrite && (exmem_wr != 5'd0) && (exmem_wr == idex_rt))
            fwdB = 2'b10;
        else if (memwb_RegWrite && (memwb_wr != 5'd0) && (memwb_wr == idex_rt))
            fwdB = 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        stallPc     = 1'b0;
        stallIfid   = 1'b0;
        stallIdex   = 1'b0;
        stallExmem  = 1'b0;
        bubbleIdex  = 1'b0;
        bubbleMemwb = 1'b0;
        flushIfid   = 1'b0;
        memErr      = 1'b0;
        case (state)
            RUN: begin
                if (memStall) begin
                    {stallPc, stallIfid, stallIdex, stallExmem, bubbleMemwb} = 5'b11111;
                    stateNext   = MEM_WAIT;
                    waitCntNext = CNT_W'(1);
                end else if (ex_redirect) begin
                    flushIfid  = 1'b1;
                    bubbleIdex = 1'b1;
                end else if (loadUse) begin
                    stallPc    = 1'b1;
                    stallIfid  = 1'b1;
                    bubbleIdex = 1'b1;
                end else if (id_jump) begin
                    flushIfid = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Younger hazards are frozen in place and re-evaluated once back in RUN
                if (!mem_ready) begin
                    {stallPc, stallIfid, stallIdex, stallExmem, bubbleMemwb} = 5'b11111;
                    if (waitCnt >= CNT_W'(MEM_TIMEOUT)) begin
                        stateNext = ERR;
                    end else begin
                        waitCntNext = waitCnt + CNT_W'(1);
                    end
                end else begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end
            end
            ERR: begin
                memErr      = 1'b1;
                flushIfid   = 1'b1;
                bubbleIdex  = 1'b1;
                stateNext   = RUN;
                waitCntNext = '0;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    // Controls are forced quiet while reset is held
    assign stall_pc     = !reset && stallPc;
    assign stall_ifid   = !reset && stallIfid;
    assign stall_idex   = !reset && stallIdex;
    assign stall_exmem  = !reset && stallExmem;
    assign bubble_idex  = !reset && bubbleIdex;
    assign bubble_memwb = !reset && bubbleMemwb;
    assign flush_ifid   = !reset && flushIfid;
    assign mem_err      = !reset && memErr;
    assign fwd_a        = reset ? 2'b00 : fwdA;
    assign fwd_b        = reset ? 2'b00 : fwdB;
    assign hz_state     = state;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stallCnt;
    logic [PERF_W-1:0] flushCnt;

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (perf_clr) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_pc && (stallCnt != '1))
                stallCnt <= stallCnt + PERF_W'(1);
            if (flush_ifid && (flushCnt != '1))
                flushCnt <= flushCnt + PERF_W'(1);
        end
    end

    assign stall_cycles = stallCnt;
    assign flush_cycles = flushCnt;
`else
    logic unusedPerfClr;
    assign unusedPerfClr = perf_clr;
    assign stall_cycles  = PERF_W'(0);
    assign flush_cycles  = PERF_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases with literal expectations plus randomized
// traffic, all checked every cycle against a rule-level model of the hazard unit.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_wr, exmem_wr, memwb_wr;
    logic        ifid_uses_rt, idex_MemRead, exmem_RegWrite, exmem_mem_access;
    logic        memwb_RegWrite, mem_ready, ex_redirect, id_jump, perf_clr;
    logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic        bubble_idex, bubble_memwb, flush_ifid, mem_err;
    logic [1:0]  fwd_a, fwd_b, hz_state;
    logic [31:0] stall_cycles, flush_cycles;

    int compared   = 0;
    int mismatched = 0;

    // Model state: cycles spent waiting on memory (0 = not waiting), pending error cycle, counters
    int          mWait = 0;
    bit          mErr  = 0;
    longint      mStall = 0;
    longint      mFlush = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_MemRead(idex_MemRead), .idex_wr(idex_wr),
        .exmem_RegWrite(exmem_RegWrite), .exmem_wr(exmem_wr), .exmem_mem_access(exmem_mem_access),
        .memwb_RegWrite(memwb_RegWrite), .memwb_wr(memwb_wr), .mem_ready(mem_ready),
        .ex_redirect(ex_redirect), .id_jump(id_jump), .perf_clr(perf_clr),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .bubble_idex(bubble_idex), .bubble_memwb(bubble_memwb),
        .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .hz_state(hz_state), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdRule(input logic [4:0] src);
        if (exmem_RegWrite && exmem_wr != 0 && exmem_wr == src) return 2'd2;
        if (memwb_RegWrite && memwb_wr != 0 && memwb_wr == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic quiet();
        {ifid_rs, ifid_rt, idex_rs, idex_rt, idex_wr, exmem_wr, memwb_wr} = '0;
        {ifid_uses_rt, idex_MemRead, exmem_RegWrite, exmem_mem_access} = '0;
        {memwb_RegWrite, ex_redirect, id_jump, perf_clr} = '0;
        mem_ready = 1'b1;
    endtask

    // Mid-cycle: compare every output against the model, then advance the model one edge
    task automatic settle();
        bit freeze, fl, bi, sp, si, me;
        bit loadUse, nextErr;
        int nextWait;
        logic [1:0] st;
        @(negedge clk);
        freeze = 0; fl = 0; bi = 0; sp = 0; si = 0; me = 0;
        nextWait = mWait; nextErr = 0;
        st = mErr ? 2'd2 : (mWait > 0 ? 2'd1 : 2'd0);
        loadUse = idex_MemRead && idex_wr != 0 &&
                  (idex_wr == ifid_rs || (ifid_uses_rt && idex_wr == ifid_rt));
        if (mErr) begin
            me = 1; fl = 1; bi = 1; nextWait = 0;
        end else if (mWait > 0) begin
            if (!mem_ready) begin
                freeze = 1;
                if (mWait >= TO) begin nextErr = 1; nextWait = 0; end
                else nextWait = mWait + 1;
            end else nextWait = 0;
        end else if (exmem_mem_access && !mem_ready) begin
            freeze = 1; nextWait = 1;
        end else if (ex_redirect) begin
            fl = 1; bi = 1;
        end else if (loadUse) begin
            sp = 1; si = 1; bi = 1;
        end else if (id_jump) begin
            fl = 1;
        end
        if (freeze) begin sp = 1; si = 1; end
        if (reset) begin
            {freeze, fl, bi, sp, si, me} = '0;
            st = 2'd0;
        end
        chk("hz_state", 32'(hz_state), 32'(st));
        chk("stall_pc", 32'(stall_pc), 32'(sp));
        chk("stall_ifid", 32'(stall_ifid), 32'(si));
        chk("stall_idex", 32'(stall_idex), 32'(freeze));
        chk("stall_exmem", 32'(stall_exmem), 32'(freeze));
        chk("bubble_memwb", 32'(bubble_memwb), 32'(freeze));
        chk("bubble_idex", 32'(bubble_idex), 32'(bi));
        chk("flush_ifid", 32'(flush_ifid), 32'(fl));
        chk("mem_err", 32'(mem_err), 32'(me));
        chk("fwd_a", 32'(fwd_a), reset ? 32'd0 : 32'(fwdRule(idex_rs)));
        chk("fwd_b", 32'(fwd_b), reset ? 32'd0 : 32'(fwdRule(idex_rt)));
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, reset ? 32'd0 : 32'(mStall));
        chk("flush_cycles", flush_cycles, reset ? 32'd0 : 32'(mFlush));
`else
        chk("stall_cycles", stall_cycles, 32'd0);
        chk("flush_cycles", flush_cycles, 32'd0);
`endif
        if (reset) begin
            mWait = 0; mErr = 0; mStall = 0; mFlush = 0;
        end else begin
            mWait = nextWait; mErr = nextErr;
            if (perf_clr) begin
                mStall = 0; mFlush = 0;
            end else begin
                if (sp && mStall < 64'hFFFF_FFFF) mStall++;
                if (fl && mFlush < 64'hFFFF_FFFF) mFlush++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    longint savedStall;
    longint savedFlush;

    initial begin
        quiet();
        reset = 1'b1;
        settle();
        chk("reset hz_state", 32'(hz_state), 32'd0);
        advance();
        reset = 1'b0;
        settle();
        advance();

        // Forwarding priority and register 0
        exmem_RegWrite = 1; exmem_wr = 5; memwb_RegWrite = 1; memwb_wr = 5; idex_rs = 5;
        settle(); chk("fwd mem prio", 32'(fwd_a), 32'd2); advance();
        exmem_wr = 0;
        settle(); chk("fwd wb", 32'(fwd_a), 32'd1); advance();
        idex_rs = 0; memwb_wr = 0;
        settle(); chk("fwd r0", 32'(fwd_a), 32'd0); advance();
        quiet();

        // Load-use, then the bubble clears MemRead
        idex_MemRead = 1; idex_wr = 8; ifid_rs = 8;
        settle();
        chk("lu stall_pc", 32'(stall_pc), 32'd1);
        chk("lu stall_ifid", 32'(stall_ifid), 32'd1);
        chk("lu bubble_idex", 32'(bubble_idex), 32'd1);
        advance();
        idex_MemRead = 0;
        settle(); chk("lu one cycle", 32'(stall_pc), 32'd0); advance();
        idex_MemRead = 1; ifid_rs = 3; ifid_rt = 8; ifid_uses_rt = 0;
        settle(); chk("lu rt unused", 32'(stall_pc), 32'd0); advance();
        quiet();

        // Memory wait resolved on cycle 3
        exmem_mem_access = 1; mem_ready = 0;
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c >= 3);
            settle();
            chk("mw freeze", 32'(stall_exmem), (c < 3) ? 32'd1 : 32'd0);
            chk("mw state", 32'(hz_state), (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
            advance();
            if (c == 3) exmem_mem_access = 0;
        end
        quiet();

        // Timeout with mem_ready held low
        exmem_mem_access = 1; mem_ready = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) begin exmem_mem_access = 0; mem_ready = 1; end
            settle();
            chk("to freeze", 32'(stall_pc), (c <= 4) ? 32'd1 : 32'd0);
            chk("to mem_err", 32'(mem_err), (c == 5) ? 32'd1 : 32'd0);
            chk("to state", 32'(hz_state), (c == 5) ? 32'd2 : ((c >= 1 && c <= 4) ? 32'd1 : 32'd0));
            advance();
        end
        quiet();

        // Redirect beats simultaneous load-use
        savedStall = mStall; savedFlush = mFlush;
        ex_redirect = 1; idex_MemRead = 1; idex_wr = 8; ifid_rs = 8;
        settle();
        chk("rd flush", 32'(flush_ifid), 32'd1);
        chk("rd bubble", 32'(bubble_idex), 32'd1);
        chk("rd no stall", 32'(stall_pc), 32'd0);
        advance();
        quiet();
        settle();
`ifdef HAZ_PERF_CNT_EN
        chk("perf flush +1", flush_cycles, 32'(savedFlush + 1));
        chk("perf stall same", stall_cycles, 32'(savedStall));
`endif
        advance();
        perf_clr = 1;
        settle(); advance();
        perf_clr = 0;
        settle();
        chk("perf clr stall", stall_cycles, 32'd0);
        chk("perf clr flush", flush_cycles, 32'd0);
        advance();

        // Async reset while waiting with wait count 3
        exmem_mem_access = 1; mem_ready = 0;
        for (int c = 0; c < 3; c++) begin settle(); advance(); end
        chk("pre-reset state", 32'(hz_state), 32'd1);
        reset = 1'b1;
        #1;
        chk("async rst state", 32'(hz_state), 32'd0);
        chk("async rst stall", 32'(stall_pc), 32'd0);
        chk("async rst freeze", 32'(stall_exmem), 32'd0);
        chk("async rst err", 32'(mem_err), 32'd0);
        settle();
        advance();
        reset = 1'b0;
        quiet();

        // Randomized traffic on a small register space to provoke matches
        for (int n = 0; n < 3000; n++) begin
            ifid_rs = 5'($urandom_range(0, 3));
            ifid_rt = 5'($urandom_range(0, 3));
            idex_rs = 5'($urandom_range(0, 3));
            idex_rt = 5'($urandom_range(0, 3));
            idex_wr = 5'($urandom_range(0, 3));
            exmem_wr = 5'($urandom_range(0, 3));
            memwb_wr = 5'($urandom_range(0, 3));
            ifid_uses_rt = 1'($urandom);
            idex_MemRead = 1'($urandom);
            exmem_RegWrite = 1'($urandom);
            memwb_RegWrite = 1'($urandom);
            exmem_mem_access = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 3) == 0);
            ex_redirect = ($urandom_range(0, 3) == 0);
            id_jump = ($urandom_range(0, 3) == 0);
            perf_clr = ($urandom_range(0, 63) == 0);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
